// File: rtl/mem_wishbone_bridge_pkg.sv
// rtl/mem_wishbone_bridge_pkg.sv - shared types and constants for the mem-to-Wishbone bridge
package mem_wishbone_bridge_pkg;

   // Bridge sequencing: idle/accepting, running a read burst, running a single write
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } wb_bridge_state_t;

   localparam int MAX_BURST_WORDS = 32;
   localparam int BEAT_W          = $clog2(MAX_BURST_WORDS);
   localparam int ADDR_W          = 30;
   localparam int DATA_W          = 32;
   localparam int SEL_W           = 4;
   localparam logic [SEL_W-1:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/mem_wishbone_bridge_timer.sv
// rtl/mem_wishbone_bridge_timer.sv - per-beat wait counter that forces a beat to complete
module wb_beat_timer #(
   parameter int TIMEOUT = 1023
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic run_i,
   output logic expire_o
);

   // TIMEOUT=0 disables expiry; the counter still exists but never fires
   localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int LAST_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] LAST = LAST_INT[CNT_W-1:0];
   localparam bit ENABLED = (TIMEOUT != 0);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Count cycles spent on the current beat; restart on terminate or when idle
   always_comb begin
      count_d = count_q;
      if (clear_i || !run_i) begin
         count_d = '0;
      end else if (count_q != LAST) begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // The beat is forced on its TIMEOUT-th cycle without a response
   assign expire_o = ENABLED && run_i && (count_q == LAST);

endmodule

// File: rtl/mem_wishbone_bridge.sv
// rtl/mem_wishbone_bridge.sv - runs the arbitrated mem request stream on a Wishbone B4 classic master
module mem_wishbone_bridge
   import mem_wishbone_bridge_pkg::*;
#(
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_request,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [BEAT_W-1:0] mem_rlen,
   input  logic              mem_rnw,
   input  logic              mem_rmw,
   input  logic [ID_W-1:0]   mem_id,
   input  logic [SEL_W-1:0]  mem_wbe,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ack,
   output logic              mem_rvalid,
   output logic [DATA_W-1:0] mem_rdata,
   output logic [ID_W-1:0]   mem_rid,
   output logic              mem_write_outstanding,
   output logic              mem_inv,
   output logic [ADDR_W-1:0] mem_inv_addr,
   output logic              wb_cyc,
   output logic              wb_stb,
   output logic              wb_we,
   output logic              wb_lock,
   output logic [ADDR_W-1:0] wb_adr,
   output logic [SEL_W-1:0]  wb_sel,
   output logic [DATA_W-1:0] wb_dat_o,
   input  logic [DATA_W-1:0] wb_dat_i,
   input  logic              wb_ack,
   input  logic              wb_err,
   output logic              bus_error
);

   wb_bridge_state_t  state_q;
   logic [ADDR_W-1:0] adr_q;
   logic [ADDR_W-1:0] adr_d;
   logic [BEAT_W-1:0] rlen_q;
   logic [BEAT_W-1:0] beat_q;
   logic [BEAT_W-1:0] beat_d;
   logic              rmw_q;
   logic [ID_W-1:0]   id_q;
   logic [SEL_W-1:0]  sel_q;
   logic [DATA_W-1:0] wdata_q;
   logic              lock_q;
   logic              rvalid_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ID_W-1:0]   rid_q;
   logic              bus_error_q;

   logic busy;
   logic expire;
   logic term;
   logic term_err;
   logic last_beat;

   assign busy      = (state_q != IDLE);
   assign term      = busy && (wb_ack || wb_err || expire);
   // err wins over ack; a timeout only counts when the slave stayed silent
   assign term_err  = wb_err || (expire && !wb_ack);
   assign last_beat = (state_q == WR) || (beat_q == rlen_q);
   assign adr_d     = adr_q + 30'd1;
   assign beat_d    = beat_q + 1'b1;

   wb_beat_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_beat_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (term),
      .run_i    (busy),
      .expire_o (expire)
   );

   // Request sequencing, beat counting, lock tracking and the response register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         adr_q       <= '0;
         rlen_q      <= '0;
         beat_q      <= '0;
         rmw_q       <= 1'b0;
         id_q        <= '0;
         sel_q       <= '0;
         wdata_q     <= '0;
         lock_q      <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         rid_q       <= '0;
         bus_error_q <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (mem_request) begin
                  adr_q   <= mem_addr;
                  rlen_q  <= mem_rlen;
                  beat_q  <= '0;
                  rmw_q   <= mem_rmw;
                  id_q    <= mem_id;
                  sel_q   <= mem_rnw ? SEL_ALL : mem_wbe;
                  wdata_q <= mem_rnw ? '0 : mem_wdata;
                  state_q <= mem_rnw ? RD : WR;
                  if (mem_rmw && mem_rnw) begin
                     lock_q <= 1'b1;
                  end
               end
            end
            RD: begin
               if (term) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= term_err ? '0 : wb_dat_i;
                  rid_q    <= id_q;
                  if (last_beat) begin
                     state_q <= IDLE;
                     // the read half of a pair keeps the bus locked for its write
                     if (!rmw_q) begin
                        lock_q <= 1'b0;
                     end
                  end else begin
                     beat_q <= beat_d;
                     adr_q  <= adr_d;
                  end
               end
            end
            WR: begin
               if (term) begin
                  state_q <= IDLE;
                  lock_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
         if (term && term_err) begin
            bus_error_q <= 1'b1;
         end
      end
   end

   assign mem_ack               = (state_q == IDLE) && mem_request;
   assign mem_write_outstanding = (mem_ack && !mem_rnw) || (state_q == WR);
   assign mem_rvalid            = rvalid_q;
   assign mem_rdata             = rdata_q;
   assign mem_rid               = rid_q;
   assign mem_inv               = 1'b0;
   assign mem_inv_addr          = '0;

   assign wb_stb    = busy;
   assign wb_cyc    = busy || lock_q;
   assign wb_we     = (state_q == WR);
   assign wb_lock   = lock_q || (busy && rmw_q);
   assign wb_adr    = adr_q;
   assign wb_sel    = sel_q;
   assign wb_dat_o  = wdata_q;
   assign bus_error = bus_error_q;

endmodule

// File: tb/tb_mem_wishbone_bridge.sv
// tb/tb_mem_wishbone_bridge.sv - randomized self-checking bench for mem_wishbone_bridge
module tb_mem_wishbone_bridge;

   logic        clk;
   logic        rst_n;
   logic        mem_request;
   logic [29:0] mem_addr;
   logic [4:0]  mem_rlen;
   logic        mem_rnw;
   logic        mem_rmw;
   logic [1:0]  mem_id;
   logic [3:0]  mem_wbe;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_rid;
   logic        mem_write_outstanding;
   logic        mem_inv;
   logic [29:0] mem_inv_addr;
   logic        wb_cyc, wb_stb, wb_we, wb_lock;
   logic [29:0] wb_adr;
   logic [3:0]  wb_sel;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack, wb_err;
   logic        bus_error;

   mem_wishbone_bridge #(.ID_W(2), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_request(mem_request), .mem_addr(mem_addr), .mem_rlen(mem_rlen),
      .mem_rnw(mem_rnw), .mem_rmw(mem_rmw), .mem_id(mem_id),
      .mem_wbe(mem_wbe), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rid(mem_rid),
      .mem_write_outstanding(mem_write_outstanding),
      .mem_inv(mem_inv), .mem_inv_addr(mem_inv_addr),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_lock(wb_lock),
      .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_ack(wb_ack), .wb_err(wb_err), .bus_error(bus_error)
   );

   wire [138:0] all_outs = {mem_ack, mem_rvalid, mem_rdata, mem_rid, mem_write_outstanding,
                            mem_inv, mem_inv_addr, wb_cyc, wb_stb, wb_we, wb_lock,
                            wb_adr, wb_sel, wb_dat_o, bus_error};

   typedef struct { logic [29:0] adr; logic we; logic [3:0] sel; logic [31:0] dat; int cyc; } beat_t;
   typedef struct { logic [31:0] data; logic [1:0] id; int cyc; } rbeat_t;

   beat_t  bq[$];
   rbeat_t rq[$];
   int checks = 0;
   int errors = 0;
   int cyc_n = 0;
   logic [31:0] data_seed;

   int slave_whi = 0;
   int slave_err_beat = -1;
   bit slave_both = 0;
   bit slave_silent = 0;
   bit lock_watch = 0;
   int lock_gaps = 0;
   int lock_samples = 0;

   function automatic logic [31:0] data_fn(input logic [29:0] a);
      return {a, 2'b01} ^ data_seed;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Slave: fixed/random wait states per beat, optional err injection, records each terminated beat
   initial begin
      int wcnt;
      int cur_wait;
      int beat_idx;
      wcnt = 0; cur_wait = 0; beat_idx = 0;
      wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
      forever begin
         @(posedge clk); #1;
         wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
         if (wb_cyc && wb_stb && !slave_silent) begin
            if (wcnt >= cur_wait) begin
               if (beat_idx == slave_err_beat) begin
                  wb_err = 1'b1;
                  wb_ack = slave_both;
               end else begin
                  wb_ack = 1'b1;
               end
               wb_dat_i = data_fn(wb_adr);
               bq.push_back('{wb_adr, wb_we, wb_sel, wb_dat_o, cyc_n});
               beat_idx++;
               wcnt = 0;
               cur_wait = int'($urandom_range(0, slave_whi));
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
            beat_idx = 0;
            cur_wait = int'($urandom_range(0, slave_whi));
         end
      end
   end

   // Response monitor and lock-continuity monitor
   always @(negedge clk) begin
      if (mem_rvalid) rq.push_back('{mem_rdata, mem_rid, cyc_n});
      if (lock_watch) begin
         lock_samples++;
         if (!(wb_cyc && wb_lock)) lock_gaps++;
      end
   end

   task automatic do_req(input logic [29:0] a, input logic [4:0] rlen, input bit rnw, input bit rmw,
                         input logic [1:0] id, input logic [3:0] wbe, input logic [31:0] wd,
                         output int lat);
      int k;
      @(posedge clk); #1;
      mem_request = 1'b1; mem_addr = a; mem_rlen = rlen; mem_rnw = rnw; mem_rmw = rmw;
      mem_id = id; mem_wbe = wbe; mem_wdata = wd;
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if (mem_ack) break;
         @(posedge clk); #1;
      end
      lat = k;
      if (k == 50) begin
         errors++;
         $display("FAIL req_ack_timeout: no mem_ack within 50 cycles, required ack");
      end
      @(posedge clk); #1;
      mem_request = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      for (k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (!wb_stb) break;
      end
      if (k == 3000) begin
         errors++;
         $display("FAIL done_timeout: wb_stb still 1 after 3000 cycles, required 0");
      end
      @(negedge clk);
   endtask

   task automatic run_txn(input logic [29:0] a, input logic [4:0] rlen, input bit rnw,
                          input logic [1:0] id, input logic [3:0] wbe, input logic [31:0] wd,
                          input int err_beat, input bit both, input int whi, output int lat);
      int nb;
      logic [29:0] ea;
      logic [31:0] ed;
      bq.delete(); rq.delete();
      slave_err_beat = err_beat; slave_both = both; slave_whi = whi; slave_silent = 0;
      do_req(a, rlen, rnw, 1'b0, id, wbe, wd, lat);
      wait_done();
      nb = rnw ? int'(rlen) + 1 : 1;
      checks++;
      if (bq.size() != nb) begin
         errors++; $display("FAIL bus_beats: got %0d, required %0d", bq.size(), nb);
      end
      checks++;
      if (rq.size() != (rnw ? nb : 0)) begin
         errors++; $display("FAIL rvalid_count: got %0d, required %0d", rq.size(), rnw ? nb : 0);
      end
      for (int i = 0; i < nb && i < bq.size(); i++) begin
         ea = a + 30'(i);
         checks++;
         if (bq[i].adr !== ea || bq[i].we !== !rnw || bq[i].sel !== (rnw ? 4'hF : wbe) ||
             (!rnw && bq[i].dat !== wd)) begin
            errors++;
            $display("FAIL bus_beat%0d adr/we/sel/dat: got %h/%b/%h/%h, required %h/%b/%h/%h",
                     i, bq[i].adr, bq[i].we, bq[i].sel, bq[i].dat, ea, !rnw, rnw ? 4'hF : wbe, wd);
         end
         if (rnw && i < rq.size()) begin
            ed = (i == err_beat) ? 32'h0 : data_fn(ea);
            checks++;
            if (rq[i].data !== ed || rq[i].id !== id || rq[i].cyc !== bq[i].cyc + 1) begin
               errors++;
               $display("FAIL rbeat%0d data/rid/cyc: got %h/%0d/%0d, required %h/%0d/%0d",
                        i, rq[i].data, rq[i].id, rq[i].cyc, ed, id, bq[i].cyc + 1);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mem_request = 1'b0; mem_addr = '0; mem_rlen = '0; mem_rnw = 1'b0; mem_rmw = 1'b0;
      mem_id = '0; mem_wbe = '0; mem_wdata = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (all_outs !== '0) begin
         errors++; $display("FAIL reset_outputs: got %h, required 0", all_outs);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (all_outs !== '0) begin
         errors++; $display("FAIL idle_after_reset: got %h, required 0", all_outs);
      end
   endtask

   task automatic test_single_read();
      int lat;
      run_txn(30'h100, 5'd0, 1'b1, 2'd1, 4'h0, 32'h0, -1, 1'b0, 0, lat);
      checks++;
      if (lat !== 0) begin
         errors++; $display("FAIL single_read_ack_latency: got %0d, required 0", lat);
      end
      checks++;
      if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
         errors++; $display("FAIL single_read_idle: cyc/stb got %b/%b, required 0/0", wb_cyc, wb_stb);
      end
   endtask

   task automatic test_burst_wrap();
      int lat;
      run_txn(30'h3FFF_FFFE, 5'd3, 1'b1, 2'd2, 4'h0, 32'h0, -1, 1'b0, 3, lat);
   endtask

   task automatic test_write();
      int lat;
      int bad;
      bad = 0;
      bq.delete(); rq.delete();
      slave_err_beat = -1; slave_both = 0; slave_whi = 0; slave_silent = 0;
      @(posedge clk); #1;
      mem_request = 1'b1; mem_addr = 30'h2A5; mem_rlen = 5'd7; mem_rnw = 1'b0; mem_rmw = 1'b0;
      mem_id = 2'd3; mem_wbe = 4'b0011; mem_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++;
      if (mem_ack !== 1'b1 || mem_write_outstanding !== 1'b1) begin
         errors++; $display("FAIL write_ack_cycle ack/outstanding: got %b/%b, required 1/1", mem_ack, mem_write_outstanding);
      end
      @(posedge clk); #1;
      mem_request = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!wb_stb) break;
         if (mem_write_outstanding !== 1'b1 || wb_we !== 1'b1 || wb_sel !== 4'b0011) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL write_during: got %0d bad cycles, required 0", bad);
      end
      checks++;
      if (mem_write_outstanding !== 1'b0) begin
         errors++; $display("FAIL write_outstanding_after: got %b, required 0", mem_write_outstanding);
      end
      @(negedge clk);
      checks++;
      if (bq.size() != 1 || rq.size() != 0) begin
         errors++; $display("FAIL write_counts beats/rvalids: got %0d/%0d, required 1/0", bq.size(), rq.size());
      end else begin
         checks++;
         if (bq[0].adr !== 30'h2A5 || bq[0].dat !== 32'hDEAD_BEEF || bq[0].sel !== 4'b0011) begin
            errors++; $display("FAIL write_beat adr/dat/sel: got %h/%h/%h, required 2a5/deadbeef/3", bq[0].adr, bq[0].dat, bq[0].sel);
         end
      end
   endtask

   task automatic test_atomic();
      int lat;
      bq.delete(); rq.delete();
      slave_err_beat = -1; slave_whi = 2; slave_silent = 0;
      lock_gaps = 0; lock_samples = 0;
      do_req(30'h40, 5'd0, 1'b1, 1'b1, 2'd0, 4'h0, 32'h0, lat);
      lock_watch = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (!wb_stb) break;
      end
      repeat (2) @(posedge clk);
      do_req(30'h40, 5'd0, 1'b0, 1'b1, 2'd0, 4'hF, 32'h1234_5678, lat);
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (!wb_stb) break;
      end
      lock_watch = 1'b0;
      checks++;
      if (lock_gaps != 0 || lock_samples < 4) begin
         errors++; $display("FAIL atomic_lock_held: got %0d gaps in %0d cycles, required 0 gaps", lock_gaps, lock_samples);
      end
      checks++;
      if (wb_lock !== 1'b0 || wb_cyc !== 1'b0) begin
         errors++; $display("FAIL atomic_release lock/cyc: got %b/%b, required 0/0", wb_lock, wb_cyc);
      end
      @(negedge clk);
      checks++;
      if (rq.size() != 1 || bq.size() != 2) begin
         errors++; $display("FAIL atomic_counts rvalids/beats: got %0d/%0d, required 1/2", rq.size(), bq.size());
      end else begin
         checks++;
         if (rq[0].data !== data_fn(30'h40) || bq[1].we !== 1'b1 || bq[1].dat !== 32'h1234_5678) begin
            errors++; $display("FAIL atomic_data rdata/we/wdat: got %h/%b/%h", rq[0].data, bq[1].we, bq[1].dat);
         end
      end
      // a plain request while locked releases the lock when it completes
      do_req(30'h80, 5'd0, 1'b1, 1'b1, 2'd1, 4'h0, 32'h0, lat);
      wait_done();
      checks++;
      if (wb_lock !== 1'b1 || wb_cyc !== 1'b1) begin
         errors++; $display("FAIL locked_idle lock/cyc: got %b/%b, required 1/1", wb_lock, wb_cyc);
      end
      do_req(30'h81, 5'd1, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0, lat);
      wait_done();
      checks++;
      if (wb_lock !== 1'b0 || wb_cyc !== 1'b0) begin
         errors++; $display("FAIL plain_unlock lock/cyc: got %b/%b, required 0/0", wb_lock, wb_cyc);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [29:0] a;
      a = 30'($urandom);
      run_txn(a, 5'd31, 1'b1, 2'd3, 4'h0, 32'h0, -1, 1'b0, 0, lat);
      for (int i = 1; i < bq.size() && i < rq.size(); i++) begin
         checks++;
         if (bq[i].cyc !== bq[0].cyc + i || rq[i].cyc !== rq[0].cyc + i) begin
            errors++; $display("FAIL b2b_beat%0d cycles bus/resp: got %0d/%0d, required %0d/%0d",
                               i, bq[i].cyc, rq[i].cyc, bq[0].cyc + i, rq[0].cyc + i);
         end
      end
   endtask

   task automatic test_random();
      int lat;
      bit rnw;
      for (int n = 0; n < 24; n++) begin
         rnw = ($urandom_range(0, 2) != 0);
         run_txn(30'($urandom), 5'($urandom_range(0, 31)), rnw, 2'($urandom), 4'($urandom),
                 $urandom, -1, 1'b0, int'($urandom_range(0, 3)), lat);
      end
      checks++;
      if (bus_error !== 1'b0) begin
         errors++; $display("FAIL no_spurious_error: got %b, required 0", bus_error);
      end
   endtask

   task automatic test_error();
      int lat;
      run_txn(30'h500, 5'd2, 1'b1, 2'd1, 4'h0, 32'h0, 1, 1'b0, 1, lat);
      checks++;
      if (bus_error !== 1'b1) begin
         errors++; $display("FAIL err_sticky: got %b, required 1", bus_error);
      end
      run_txn(30'h600, 5'd1, 1'b1, 2'd2, 4'h0, 32'h0, 0, 1'b1, 0, lat);
   endtask

   task automatic test_timeout();
      int lat;
      int cnt;
      cnt = 0;
      bq.delete(); rq.delete();
      slave_silent = 1;
      do_req(30'h700, 5'd0, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0, lat);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!wb_stb) break;
         cnt++;
      end
      @(negedge clk);
      slave_silent = 0;
      checks++;
      if (cnt != 8) begin
         errors++; $display("FAIL timeout_cycles: got %0d, required 8", cnt);
      end
      checks++;
      if (rq.size() != 1 || bus_error !== 1'b1) begin
         errors++; $display("FAIL timeout_resp count/bus_error: got %0d/%b, required 1/1", rq.size(), bus_error);
      end else begin
         checks++;
         if (rq[0].data !== 32'h0 || rq[0].id !== 2'd2) begin
            errors++; $display("FAIL timeout_beat data/rid: got %h/%0d, required 0/2", rq[0].data, rq[0].id);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      int lat;
      int k;
      bq.delete(); rq.delete();
      slave_err_beat = -1; slave_whi = 1; slave_silent = 0;
      do_req(30'h900, 5'd7, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0, lat);
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bq.size() >= 2) break;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (all_outs !== '0) begin
         errors++; $display("FAIL async_reset_outputs: got %h, required 0", all_outs);
      end
      rq.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (rq.size() != 0 || wb_cyc !== 1'b0 || bus_error !== 1'b0) begin
         errors++; $display("FAIL post_reset_quiet rvalids/cyc/bus_error: got %0d/%b/%b, required 0/0/0", rq.size(), wb_cyc, bus_error);
      end
      run_txn(30'hA00, 5'd1, 1'b1, 2'd3, 4'h0, 32'h0, -1, 1'b0, 0, lat);
      checks++;
      if (lat !== 0) begin
         errors++; $display("FAIL post_reset_ack_latency: got %0d, required 0", lat);
      end
   endtask

   initial begin
      data_seed = $urandom;
      test_reset();
      test_single_read();
      test_burst_wrap();
      test_write();
      test_atomic();
      test_back_to_back();
      test_random();
      test_error();
      test_timeout();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

endmodule
